// File: rtl/moving_avg_pkg.sv
// Shared constants and elaboration-time helpers for the moving-window averager.
package moving_avg_pkg;

    // Largest supported window exponent (window of 64 samples).
    localparam int MAX_LOG2_DEPTH = 6;

    // Rounding constant added before the divide-by-depth shift.
    // Half-up needs 2**(log2_depth-1); floor mode or a one-entry window adds nothing.
    function automatic int rnd_const(input int round, input int log2_depth);
        if (round != 0 && log2_depth > 0) begin
            return 1 << (log2_depth - 1);
        end
        return 0;
    endfunction

    // Pointer width, kept at least one bit so a one-entry window still has a legal vector.
    function automatic int ptr_width(input int log2_depth);
        return (log2_depth > 0) ? log2_depth : 1;
    endfunction

endpackage

// File: rtl/moving_avg_delay_line.sv
// Sample ring buffer: stores the last DEPTH accepted samples and exposes the
// entry about to be overwritten so the caller can subtract it from a running sum.
module moving_avg_delay_line
    import moving_avg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PTR_W = ptr_width(LOG2_DEPTH);

    logic [DATA_W-1:0] entry_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;

    // Pointer wraps naturally at the power-of-two depth; a one-entry window never moves.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        if (LOG2_DEPTH > 0) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
    end

    // Write pointer: advances on every accepted sample, cleared by rst or clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
        end else if (we) begin
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // One register per entry so every slot can be zeroed at once by rst/clr.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry gi: capture the sample when the pointer addresses this slot.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (clr) begin
                    entry_reg[gi] <= '0;
                end else if (we && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Oldest sample is the one the next write will replace; empty slots read as zero.
    assign oldest = entry_reg[wr_ptr_reg];

endmodule

// File: rtl/moving_avg.sv
// Moving-window sum and rounded average over the last 2**LOG2_DEPTH accepted
// signed samples, with output strobe, window-full flag and synchronous clear.
module moving_avg
    import moving_avg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic        [DATA_W-1:0]       in_data,
    output logic signed [DATA_W+LOG2_DEPTH-1:0] sum,
    output logic signed [DATA_W-1:0]       avg,
    output logic                           out_valid,
    output logic                           window_full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic signed [SUM_W:0] RND_K = (SUM_W + 1)'(rnd_const(ROUND, LOG2_DEPTH));

    logic                    accept;
    logic [DATA_W-1:0]       oldest;
    logic signed [SUM_W-1:0] in_ext;
    logic signed [SUM_W-1:0] old_ext;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W:0]   rnd_sum;
    logic signed [DATA_W-1:0] avg_next;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;

    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [DATA_W-1:0] avg_reg;
    logic                     out_valid_reg;
    logic                     window_full_reg;

    // A clear on the same edge discards the incoming sample.
    assign accept = in_valid && !clr;

    moving_avg_delay_line #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .we      (accept),
        .wr_data (in_data),
        .oldest  (oldest)
    );

    // Running-sum update, rounding and shift; SUM_W bits cannot overflow for a full window.
    always_comb begin
        in_ext   = SUM_W'($signed(in_data));
        old_ext  = SUM_W'($signed(oldest));
        sum_next = sum_reg + in_ext - old_ext;
        // One extra bit so adding the rounding constant to the largest sum cannot wrap.
        rnd_sum  = (SUM_W + 1)'(sum_next) + RND_K;
        avg_next = DATA_W'(rnd_sum >>> LOG2_DEPTH);
        count_next = (count_reg == CNT_W'(DEPTH)) ? count_reg : count_reg + 1'b1;
    end

    // Accumulator, average, fill counter and output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg         <= '0;
            avg_reg         <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            window_full_reg <= 1'b0;
        end else if (clr) begin
            sum_reg         <= '0;
            avg_reg         <= '0;
            count_reg       <= '0;
            out_valid_reg   <= 1'b0;
            window_full_reg <= 1'b0;
        end else if (accept) begin
            sum_reg         <= sum_next;
            avg_reg         <= avg_next;
            count_reg       <= count_next;
            out_valid_reg   <= 1'b1;
            window_full_reg <= (count_next == CNT_W'(DEPTH));
        end else begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign sum         = sum_reg;
    assign avg         = avg_reg;
    assign out_valid   = out_valid_reg;
    assign window_full = window_full_reg;

endmodule

// File: tb/tb_moving_avg.sv
// Directed bench for moving_avg: half-up instance plus a floor-rounding twin.
module tb_moving_avg;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic [7:0]        in_data;
    logic signed [9:0] sum;
    logic signed [7:0] avg;
    logic              out_valid;
    logic              window_full;
    logic signed [9:0] sum_fl;
    logic signed [7:0] avg_fl;
    logic              out_valid_fl;
    logic              window_full_fl;

    int checks = 0;
    int errors = 0;

    moving_avg #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .sum(sum), .avg(avg), .out_valid(out_valid), .window_full(window_full)
    );

    moving_avg #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(0)) dut_fl (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .sum(sum_fl), .avg(avg_fl), .out_valid(out_valid_fl), .window_full(window_full_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for a single edge, then sample outputs 1 ns after that edge.
    task automatic send(input int d, input logic v, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = 8'(d);
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        checks++;
        if (sum !== 10'sd0 || avg !== 8'sd0 || out_valid !== 1'b0 || window_full !== 1'b0) begin
            $display("FAIL reset: sum=%0d avg=%0d ov=%0b wf=%0b, want all 0", sum, avg, out_valid, window_full);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released sum=%0d avg=%0d", sum, avg);
    endtask

    task automatic test_fill();
        int vals [4] = '{10, 20, 30, 40};
        int esum [4] = '{10, 30, 60, 100};
        int eavg [4] = '{3, 8, 15, 25};
        for (int i = 0; i < 4; i++) begin
            send(vals[i], 1'b1, 1'b0);
            $display("fill in=%0d sum=%0d avg=%0d ov=%0b wf=%0b", vals[i], sum, avg, out_valid, window_full);
            checks++;
            if (sum !== 10'(esum[i]) || avg !== 8'(eavg[i]) || out_valid !== 1'b1 || window_full !== (i == 3)) begin
                $display("FAIL fill[%0d]: sum=%0d avg=%0d ov=%0b wf=%0b, want sum=%0d avg=%0d ov=1 wf=%0b",
                         i, sum, avg, out_valid, window_full, esum[i], eavg[i], (i == 3));
                errors++;
            end
        end
    endtask

    task automatic test_slide();
        send(50, 1'b1, 1'b0);
        $display("slide in=50 sum=%0d avg=%0d", sum, avg);
        checks++;
        if (sum !== 10'sd140 || avg !== 8'sd35 || window_full !== 1'b1) begin
            $display("FAIL slide: sum=%0d avg=%0d wf=%0b, want sum=140 avg=35 wf=1", sum, avg, window_full);
            errors++;
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 4; i++) send(-128, 1'b1, 1'b0);
        $display("extreme neg sum=%0d avg=%0d", sum, avg);
        checks++;
        if (sum !== -10'sd512 || avg !== -8'sd128) begin
            $display("FAIL extreme_neg: sum=%0d avg=%0d, want sum=-512 avg=-128", sum, avg);
            errors++;
        end
        for (int i = 0; i < 4; i++) send(127, 1'b1, 1'b0);
        $display("extreme pos sum=%0d avg=%0d", sum, avg);
        checks++;
        if (sum !== 10'sd508 || avg !== 8'sd127) begin
            $display("FAIL extreme_pos: sum=%0d avg=%0d, want sum=508 avg=127", sum, avg);
            errors++;
        end
    endtask

    task automatic test_round0();
        int vals [4] = '{1, 1, 1, 2};
        for (int i = 0; i < 4; i++) send(vals[i], 1'b1, 1'b0);
        $display("round0 sum=%0d avg_floor=%0d avg_round=%0d", sum_fl, avg_fl, avg);
        checks++;
        if (sum_fl !== 10'sd5 || avg_fl !== 8'sd1) begin
            $display("FAIL round0_floor: sum=%0d avg=%0d, want sum=5 avg=1", sum_fl, avg_fl);
            errors++;
        end
        checks++;
        if (avg !== 8'sd1) begin
            $display("FAIL round0_halfup: avg=%0d, want 1", avg);
            errors++;
        end
    endtask

    task automatic test_gaps();
        // Window is {1,1,1,2}; 5 evicts the first 1, 9 evicts the second.
        send(5, 1'b1, 1'b0);
        $display("gap accept in=5 sum=%0d avg=%0d ov=%0b", sum, avg, out_valid);
        checks++;
        if (sum !== 10'sd9 || avg !== 8'sd2 || out_valid !== 1'b1) begin
            $display("FAIL gap_accept1: sum=%0d avg=%0d ov=%0b, want sum=9 avg=2 ov=1", sum, avg, out_valid);
            errors++;
        end
        for (int i = 0; i < 2; i++) begin
            send(77, 1'b0, 1'b0);
            $display("gap idle sum=%0d avg=%0d ov=%0b", sum, avg, out_valid);
            checks++;
            if (sum !== 10'sd9 || avg !== 8'sd2 || out_valid !== 1'b0) begin
                $display("FAIL gap_idle[%0d]: sum=%0d avg=%0d ov=%0b, want sum=9 avg=2 ov=0", i, sum, avg, out_valid);
                errors++;
            end
        end
        send(9, 1'b1, 1'b0);
        $display("gap accept in=9 sum=%0d avg=%0d ov=%0b", sum, avg, out_valid);
        checks++;
        if (sum !== 10'sd17 || avg !== 8'sd4 || out_valid !== 1'b1) begin
            $display("FAIL gap_accept2: sum=%0d avg=%0d ov=%0b, want sum=17 avg=4 ov=1", sum, avg, out_valid);
            errors++;
        end
    endtask

    task automatic test_clear();
        send(99, 1'b1, 1'b1);
        $display("clear with in=99 sum=%0d avg=%0d ov=%0b wf=%0b", sum, avg, out_valid, window_full);
        checks++;
        if (sum !== 10'sd0 || avg !== 8'sd0 || out_valid !== 1'b0 || window_full !== 1'b0) begin
            $display("FAIL clear: sum=%0d avg=%0d ov=%0b wf=%0b, want all 0", sum, avg, out_valid, window_full);
            errors++;
        end
        send(7, 1'b1, 1'b0);
        $display("after clear in=7 sum=%0d avg=%0d wf=%0b", sum, avg, window_full);
        checks++;
        if (sum !== 10'sd7 || avg !== 8'sd2 || window_full !== 1'b0) begin
            $display("FAIL clear_next: sum=%0d avg=%0d wf=%0b, want sum=7 avg=2 wf=0", sum, avg, window_full);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        send(20, 1'b1, 1'b0);
        send(30, 1'b1, 1'b0);
        // Still high from the last accept; reset lands mid-cycle with no edge in between.
        #2;
        rst = 1'b1;
        #1;
        $display("async rst sum=%0d avg=%0d ov=%0b wf=%0b", sum, avg, out_valid, window_full);
        checks++;
        if (sum !== 10'sd0 || avg !== 8'sd0 || out_valid !== 1'b0 || window_full !== 1'b0) begin
            $display("FAIL async_reset: sum=%0d avg=%0d ov=%0b wf=%0b, want all 0", sum, avg, out_valid, window_full);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        send(4, 1'b1, 1'b0);
        $display("after rst in=4 sum=%0d avg=%0d", sum, avg);
        checks++;
        if (sum !== 10'sd4 || avg !== 8'sd1 || out_valid !== 1'b1) begin
            $display("FAIL async_reset_next: sum=%0d avg=%0d ov=%0b, want sum=4 avg=1 ov=1", sum, avg, out_valid);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_slide();
        test_extremes();
        test_round0();
        test_gaps();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
